adder_nbit_pipelined: RTL and testbench



---
 rtl/adder_nbit_pipelined.sv | 150 +++++++++++++++
 tb/tb_adder_nbit_pipelined.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_nbit_pipelined.sv
// Pipelined N-bit adder/subtractor: STAGES ripple slices of CHUNK full-adder cells,
// with the carry and the not-yet-consumed operand chunks registered between slices.
module adder_nbit_pipelined #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("adder_nbit_pipelined: WIDTH must be >= 2 and a multiple of STAGES");
  end

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Bubbles load zeros so nothing undefined ever enters the pipeline.
  logic [WIDTH-1:0] a_src;
  logic [WIDTH-1:0] b_src;
  logic             cin_src;

  always_comb begin
    a_src   = '0;
    b_src   = '0;
    cin_src = 1'b0;
    if (valid_in) begin
      a_src   = a;
      b_src   = sub ? ~b : b;
      cin_src = sub | carry_in;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BIN = WIDTH - CHUNK * k;
    localparam int REM = BIN - CHUNK;

    logic             valid_d;
    logic             cin_k;
    logic [WIDTH-1:0] word_k;
    logic [BIN-1:0]   b_k;

    logic             valid_q;
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [CHUNK-1:0] chunk_sum;

    if (k == 0) begin : g_src
      assign valid_d = valid_in;
      assign cin_k   = cin_src;
      assign word_k  = a_src;
      assign b_k     = b_src;
    end else begin : g_src
      assign valid_d = g_stage[k-1].valid_q;
      assign cin_k   = g_stage[k-1].carry_q;
      assign word_k  = g_stage[k-1].word_q;
      assign b_k     = g_stage[k-1].g_rest.b_q;
    end

    always_comb begin : ripple
      logic       c;
      logic [1:0] fa;
      c         = cin_k;
      fa        = '0;
      chunk_sum = '0;
      for (int i = 0; i < CHUNK; i++) begin
        fa           = full_add(word_k[i], b_k[i], c);
        chunk_sum[i] = fa[0];
        c            = fa[1];
      end
      carry_d = c;
    end

    // word holds finished sum chunks at the top and unconsumed A chunks at the bottom,
    // so after the last slice it is exactly the aligned result.
    if (CHUNK == WIDTH) begin : g_word
      always_comb word_d = chunk_sum;
    end else begin : g_word
      always_comb word_d = {chunk_sum, word_k[WIDTH-1:CHUNK]};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        word_q  <= '0;
      end else if (!stall) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        word_q  <= word_d;
      end
    end

    if (REM > 0) begin : g_rest
      logic [REM-1:0] b_q;
      logic [REM-1:0] b_d;

      always_comb b_d = b_k[BIN-1:CHUNK];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b_q <= '0;
        end else if (!stall) begin
          b_q <= b_d;
        end
      end
    end

    // Carry into the MSB cell recovered from its sum bit: s = x ^ y ^ c.
    if (k == STAGES - 1) begin : g_flags
      logic ovf_q;
      logic ovf_d;

      always_comb ovf_d = (chunk_sum[CHUNK-1] ^ word_k[CHUNK-1] ^ b_k[CHUNK-1]) ^ carry_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign valid_out = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].word_q;
  assign carry_out = g_stage[STAGES-1].carry_q;
  assign overflow  = g_stage[STAGES-1].g_flags.ovf_q;

  a_inputs_known: assert property (@(posedge clk) disable iff (rst)
    (valid_in && !stall) |-> !$isunknown({a, b, carry_in, sub}))
    else $error("adder_nbit_pipelined: X/Z on a, b, carry_in or sub while accepting");

endmodule

// File: tb/tb_adder_nbit_pipelined.sv
// Drives four adder configurations (16/4, 8/1, 8/8, 32/4) with one shared stimulus stream
// and compares every output against an arithmetic reference model with per-config latency.
module tb_adder_nbit_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        stall;
  logic        sub;
  logic        carry_in;
  logic [31:0] a32;
  logic [31:0] b32;

  logic        vo16, co16, ov16;
  logic [15:0] sum16;
  logic        vo8a, co8a, ov8a;
  logic [7:0]  sum8a;
  logic        vo8b, co8b, ov8b;
  logic [7:0]  sum8b;
  logic        vo32, co32, ov32;
  logic [31:0] sum32;

  always #5 clk = ~clk;

  adder_nbit_pipelined #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .sub(sub), .carry_in(carry_in),
    .a(a32[15:0]), .b(b32[15:0]), .valid_out(vo16), .sum(sum16), .carry_out(co16), .overflow(ov16));

  adder_nbit_pipelined #(.WIDTH(8), .STAGES(1)) u_dut8s1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .sub(sub), .carry_in(carry_in),
    .a(a32[7:0]), .b(b32[7:0]), .valid_out(vo8a), .sum(sum8a), .carry_out(co8a), .overflow(ov8a));

  adder_nbit_pipelined #(.WIDTH(8), .STAGES(8)) u_dut8s8 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .sub(sub), .carry_in(carry_in),
    .a(a32[7:0]), .b(b32[7:0]), .valid_out(vo8b), .sum(sum8b), .carry_out(co8b), .overflow(ov8b));

  adder_nbit_pipelined #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .sub(sub), .carry_in(carry_in),
    .a(a32), .b(b32), .valid_out(vo32), .sum(sum32), .carry_out(co32), .overflow(ov32));

  logic        valid_o [4];
  logic [31:0] sum_o   [4];
  logic        cout_o  [4];
  logic        ovf_o   [4];

  always_comb begin
    valid_o[0] = vo16; sum_o[0] = {16'b0, sum16}; cout_o[0] = co16; ovf_o[0] = ov16;
    valid_o[1] = vo8a; sum_o[1] = {24'b0, sum8a}; cout_o[1] = co8a; ovf_o[1] = ov8a;
    valid_o[2] = vo8b; sum_o[2] = {24'b0, sum8b}; cout_o[2] = co8b; ovf_o[2] = ov8b;
    valid_o[3] = vo32; sum_o[3] = sum32;          cout_o[3] = co32; ovf_o[3] = ov32;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    int          cap;
  } op_t;

  op_t         ops[$];
  int          ptr [4];
  int          adv;
  logic        exp_valid [4];
  logic [31:0] exp_sum   [4];
  logic        exp_cout  [4];
  logic        exp_ovf   [4];
  int          errors = 0;
  int          checks = 0;

  function automatic int widthOf(int i);
    case (i)
      0:       return 16;
      1, 2:    return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int stagesOf(int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic longint toSigned(longint unsigned v, int w);
    longint unsigned half = 64'd1 << (w - 1);
    if (v >= half) return longint'(v) - longint'(64'd1 << w);
    return longint'(v);
  endfunction

  // Plain integer arithmetic: returns {overflow, carry_out, sum}
  function automatic logic [33:0] refAdd(int w, logic [31:0] av, logic [31:0] bv,
                                         logic s, logic ci);
    longint unsigned mask, ua, ub, tot;
    longint          sr, lim;
    logic            co;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'b0, av} & mask;
    ub   = {32'b0, bv} & mask;
    if (s) begin
      tot = (ua - ub) & mask;
      co  = (ua >= ub);
      sr  = toSigned(ua, w) - toSigned(ub, w);
    end else begin
      tot = ua + ub + {63'b0, ci};
      co  = ((tot >> w) & 64'd1) != 0;
      tot = tot & mask;
      sr  = toSigned(ua, w) + toSigned(ub, w) + longint'({63'b0, ci});
    end
    lim = longint'(64'd1 << (w - 1));
    return {(sr >= lim) || (sr < -lim), co, tot[31:0]};
  endfunction

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic modelEdge();
    logic [33:0] r;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        ptr[i] = ops.size();
        exp_valid[i] = 1'b0;
        exp_sum[i] = '0;
        exp_cout[i] = 1'b0;
        exp_ovf[i] = 1'b0;
      end
    end else if (!stall) begin
      adv++;
      if (valid_in) ops.push_back('{a: a32, b: b32, sub: sub, cin: carry_in, cap: adv});
      for (int i = 0; i < 4; i++) begin
        if (ptr[i] < ops.size() && ops[ptr[i]].cap + stagesOf(i) - 1 == adv) begin
          r = refAdd(widthOf(i), ops[ptr[i]].a, ops[ptr[i]].b, ops[ptr[i]].sub, ops[ptr[i]].cin);
          exp_sum[i]   = r[31:0];
          exp_cout[i]  = r[32];
          exp_ovf[i]   = r[33];
          exp_valid[i] = 1'b1;
          ptr[i]++;
        end else begin
          exp_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("valid_out[%0d]", i), {31'b0, valid_o[i]}, {31'b0, exp_valid[i]});
      if (exp_valid[i] || rst) begin
        checkOutput($sformatf("sum[%0d]", i), sum_o[i], exp_sum[i]);
        checkOutput($sformatf("carry_out[%0d]", i), {31'b0, cout_o[i]}, {31'b0, exp_cout[i]});
        checkOutput($sformatf("overflow[%0d]", i), {31'b0, ovf_o[i]}, {31'b0, exp_ovf[i]});
      end
    end
  endtask

  task automatic applyStimulus(logic v, logic [31:0] av, logic [31:0] bv, logic s, logic ci,
                               logic st, logic r);
    valid_in = v;
    a32      = av;
    b32      = bv;
    sub      = s;
    carry_in = ci;
    stall    = st;
    rst      = r;
    step();
  endtask

  task automatic bubble();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Directed 16-bit op with hard-coded expectations for the 16/4 instance
  task automatic directedOp(logic [15:0] av, logic [15:0] bv, logic s, logic ci,
                            logic [15:0] wantSum, logic wantC, logic wantO, string tag);
    applyStimulus(1'b1, {16'b0, av}, {16'b0, bv}, s, ci, 1'b0, 1'b0);
    checkOutput({tag, "_lat1"}, {31'b0, vo16}, 32'd0);
    bubble();
    checkOutput({tag, "_lat2"}, {31'b0, vo16}, 32'd0);
    bubble();
    checkOutput({tag, "_lat3"}, {31'b0, vo16}, 32'd0);
    bubble();
    checkOutput({tag, "_valid"}, {31'b0, vo16}, 32'd1);
    checkOutput({tag, "_sum"}, {16'b0, sum16}, {16'b0, wantSum});
    checkOutput({tag, "_cout"}, {31'b0, co16}, {31'b0, wantC});
    checkOutput({tag, "_ovf"}, {31'b0, ov16}, {31'b0, wantO});
  endtask

  initial begin
    adv = 0;
    for (int i = 0; i < 4; i++) begin
      ptr[i] = 0;
      exp_valid[i] = 1'b0;
      exp_sum[i] = '0;
      exp_cout[i] = 1'b0;
      exp_ovf[i] = 1'b0;
    end
    valid_in = 1'b0; stall = 1'b0; sub = 1'b0; carry_in = 1'b0;
    a32 = '0; b32 = '0; rst = 1'b1;

    applyStimulus(1'b1, 32'h1234, 32'h5678, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    directedOp(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "fill");
    directedOp(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple");
    directedOp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    directedOp(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), (i >= 4 && i <= 6), 1'b0);
    end
    for (int i = 0; i < 10; i++) bubble();

    applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) bubble();

    for (int i = 0; i < 1450; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
    end
    for (int i = 0; i < 10; i++) bubble();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
